// File: rtl/stopwatch_multi_cu_if.sv
// Button/selection inputs and per-channel control outputs of the
// multi-channel stopwatch control unit, bundled as one interface.
// The master side drives buttons and reads controls; the slave side is the control unit.
interface stopwatch_multi_cu_if #(
    parameter int N_CH = 2
);
    localparam int SEL_W = $clog2(N_CH);

    logic              i_runstop;
    logic              i_clear;
    logic              i_lap;
    logic [SEL_W-1:0]  i_sel;
    logic              sw;
    logic [N_CH-1:0]   o_run;
    logic [N_CH-1:0]   o_clear;
    logic [N_CH-1:0]   o_freeze;
    logic              o_mode;
    logic              o_sel_run;

    modport master (
        output i_runstop, i_clear, i_lap, i_sel, sw,
        input  o_run, o_clear, o_freeze, o_mode, o_sel_run
    );

    modport slave (
        input  i_runstop, i_clear, i_lap, i_sel, sw,
        output o_run, o_clear, o_freeze, o_mode, o_sel_run
    );
endinterface

// File: rtl/stopwatch_multi_cu.sv
// Multi-channel stopwatch control unit: N_CH independent STOP/RUN/LAP/CLEAR
// FSMs. Button rising edges are routed only to the channel picked by i_sel;
// out-of-range selections drop the event. Outputs are registered state decodes.
// Optional feature macro: LONGPRESS_CLEAR_EN (clear requires a HOLD_CYC-cycle hold).
module stopwatch_multi_cu #(
    parameter int N_CH     = 2,
    parameter int CLR_CYC  = 4,
    parameter int HOLD_CYC = 100
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_multi_cu_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int CW    = $clog2(CLR_CYC + 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_LAP,
        ST_CLEAR
    } state_e;

    logic [SEL_W-1:0] sel;
    logic             prev_runstop_q;
    logic             prev_lap_q;
    logic             ev_runstop;
    logic             ev_lap;
    logic             ev_clear;
    logic [N_CH-1:0]  hit;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CW-1:0]    cnt_q   [N_CH];
    logic [CW-1:0]    cnt_d   [N_CH];
    logic [N_CH-1:0]  run_q;
    logic [N_CH-1:0]  clr_q;
    logic [N_CH-1:0]  frz_q;
    logic             sel_run;

    assign sel = bus.i_sel;

    // Shared button history; reset to 1 so buttons held through reset do not fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_runstop_q <= 1'b1;
            prev_lap_q     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prev_runstop_q <= bus.i_runstop;
            prev_lap_q     <= bus.i_lap;
        end
    end

    assign ev_runstop = bus.i_runstop & ~prev_runstop_q;
    assign ev_lap     = bus.i_lap     & ~prev_lap_q;

`ifdef LONGPRESS_CLEAR_EN
    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    hold_d;
    logic [SEL_W-1:0] sel_prev_q;
    logic             hold_ok;

    // A hold only continues while clear stays high on an unchanged selection.
    assign hold_ok  = bus.i_clear && (sel == sel_prev_q);
    assign ev_clear = hold_ok && (hold_q == HW'(HOLD_CYC - 1));

    // Saturating hold counter: fires once on reaching HOLD_CYC, then parks there.
    always_comb begin
        hold_d = hold_q;
        if (!hold_ok) begin
            hold_d = '0;
        end else if (hold_q != HW'(HOLD_CYC)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter and the selection it was counted against.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            sel_prev_q <= '0;
        end else begin
            hold_q     <= hold_d;
            sel_prev_q <= sel;
        end
    end
`else
    logic prev_clear_q;
    logic unused_hold_cfg;

    // HOLD_CYC only shapes the long-press build.
    assign unused_hold_cfg = (HOLD_CYC > 0);
    assign ev_clear        = bus.i_clear & ~prev_clear_q;

    // Clear-button history for plain edge-triggered clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_clear_q <= 1'b1;
        end else begin
            prev_clear_q <= bus.i_clear;
        end
    end
`endif

    // One-hot channel select; an out-of-range i_sel matches no channel.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            hit[c] = (int'(sel) == c);
        end
    end

    // Per-channel next state, with priority clear > runstop > lap.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            // NOTE: defaults first so every path assigns every variable and no latch is inferred.
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                ST_STOP: begin
                    if (hit[c] && ev_clear) begin
                        state_d[c] = ST_CLEAR;
                        cnt_d[c]   = '0;
                    end else if (hit[c] && ev_runstop) begin
                        state_d[c] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hit[c] && ev_runstop) begin
                        state_d[c] = ST_STOP;
                    end else if (hit[c] && ev_lap) begin
                        state_d[c] = ST_LAP;
                    end
                end
                ST_LAP: begin
                    if (hit[c] && ev_runstop) begin
                        state_d[c] = ST_STOP;
                    end else if (hit[c] && ev_lap) begin
                        state_d[c] = ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q[c] == CW'(CLR_CYC - 1)) begin
                        state_d[c] = ST_STOP;
                        cnt_d[c]   = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end
                default: begin
                    state_d[c] = ST_STOP;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    // Channel state, clear counters and Moore outputs decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_STOP;
                cnt_q[c]   <= '0;
            end
            run_q <= '0;
            clr_q <= '0;
            frz_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                run_q[c]   <= (state_d[c] == ST_RUN) || (state_d[c] == ST_LAP);
                frz_q[c]   <= (state_d[c] == ST_LAP);
                clr_q[c]   <= (state_d[c] == ST_CLEAR);
            end
        end
    end

    // Run status of the currently selected channel; 0 when nothing is selected.
    always_comb begin
        sel_run = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (hit[c]) begin
                sel_run = run_q[c];
            end
        end
    end

    assign bus.o_run     = run_q;
    assign bus.o_clear   = clr_q;
    assign bus.o_freeze  = frz_q;
    assign bus.o_mode    = bus.sw;
    assign bus.o_sel_run = sel_run;
endmodule

// File: tb/tb_stopwatch_multi_cu.sv
// Scoreboard bench for stopwatch_multi_cu with three channels.
// The driver pushes hand-computed post-edge outputs; the monitor pops and
// compares them one clock edge later, 1 time unit after the edge.
module tb_stopwatch_multi_cu;
  localparam int N_CH     = 3;
  localparam int CLR_CYC  = 4;
  localparam int HOLD_CYC = 100;

  typedef struct {
    int         cyc;
    logic [2:0] run;
    logic [2:0] clr;
    logic [2:0] frz;
    logic       sel_run;
    logic       mode;
    string      name;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sw_t  = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t m_e;

  stopwatch_multi_cu_if #(.N_CH(N_CH)) bus ();

  stopwatch_multi_cu #(
    .N_CH    (N_CH),
    .CLR_CYC (CLR_CYC),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record one comparison result and report a mismatch.
  task automatic check(input bit ok, input string nm, input string detail);
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d: %s", nm, cyc, detail);
    end
  endtask

  // Drive one cycle of buttons at the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input logic rs, input logic cl, input logic lp, input logic [1:0] sel,
                      input logic [2:0] er, input logic [2:0] ec, input logic [2:0] ef,
                      input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    sw_t          = ~sw_t;
    bus.i_runstop = rs;
    bus.i_clear   = cl;
    bus.i_lap     = lp;
    bus.i_sel     = sel;
    bus.sw        = sw_t;
    e.cyc     = cyc + 1;
    e.run     = er;
    e.clr     = ec;
    e.frz     = ef;
    e.sel_run = es;
    e.mode    = sw_t;
    e.name    = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation that falls due at this edge.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      check(m_e.cyc == cyc, m_e.name,
            $sformatf("compared late, due cyc %0d", m_e.cyc));
      check(bus.o_run === m_e.run, m_e.name,
            $sformatf("o_run=%b expected %b", bus.o_run, m_e.run));
      check(bus.o_clear === m_e.clr, m_e.name,
            $sformatf("o_clear=%b expected %b", bus.o_clear, m_e.clr));
      check(bus.o_freeze === m_e.frz, m_e.name,
            $sformatf("o_freeze=%b expected %b", bus.o_freeze, m_e.frz));
      check(bus.o_sel_run === m_e.sel_run, m_e.name,
            $sformatf("o_sel_run=%b expected %b", bus.o_sel_run, m_e.sel_run));
      check(bus.o_mode === m_e.mode, m_e.name,
            $sformatf("o_mode=%b expected %b", bus.o_mode, m_e.mode));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_runstop = 1'b1;
    bus.i_clear   = 1'b0;
    bus.i_lap     = 1'b0;
    bus.i_sel     = 2'd0;
    bus.sw        = 1'b0;

    // Reset state, then release with runstop still held: no edge may fire.
    step(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "reset_state");
    step(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "held_through_reset");
    reset = 1'b0;
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "release");

    // Run/stop toggling on channel 0.
    step(1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "rs_start");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_hold");
    step(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "rs_stop");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "stop_hold");

    // Lap enter/exit and runstop out of LAP.
    step(1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_again");
    step(0, 0, 1, 0, 3'b001, 3'b000, 3'b001, 1, "lap_enter");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b001, 1, "lap_hold");
    step(0, 0, 1, 0, 3'b001, 3'b000, 3'b000, 1, "lap_exit");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_hold2");
    step(0, 0, 1, 0, 3'b001, 3'b000, 3'b001, 1, "lap_enter2");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b001, 1, "lap_hold2");
    step(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "rs_from_lap");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "stop_hold2");

`ifndef LONGPRESS_CLEAR_EN
    // Clear pulse lasts exactly CLR_CYC cycles; runstop inside CLEAR is ignored.
    step(0, 1, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clr_enter");
    step(1, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "rs_in_clear");
    step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clear_c3");
    step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clear_c4");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "clear_done");

    // Clear beats runstop in STOP; runstop beats lap in RUN; clear ignored in RUN.
    step(1, 1, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clr_beats_rs");
    step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clear2_c2");
    step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clear2_c3");
    step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "clear2_c4");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "clear2_done");
    step(1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_for_ignore");
    step(0, 1, 0, 0, 3'b001, 3'b000, 3'b000, 1, "clr_ignored_run");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_hold3");
    step(1, 0, 1, 0, 3'b000, 3'b000, 3'b000, 0, "rs_beats_lap");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "stop_hold3");
`endif

    // Channel routing, shared history across i_sel changes, out-of-range select.
    step(1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "ch0_start");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "ch0_hold");
    step(1, 0, 0, 1, 3'b011, 3'b000, 3'b000, 1, "ch1_start");
    step(0, 0, 0, 1, 3'b011, 3'b000, 3'b000, 1, "ch1_hold");
    step(1, 0, 0, 2, 3'b111, 3'b000, 3'b000, 1, "ch2_start");
    step(1, 0, 0, 0, 3'b111, 3'b000, 3'b000, 1, "sel_change_no_edge");
    step(0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 1, "all_run");
    step(1, 0, 0, 3, 3'b111, 3'b000, 3'b000, 0, "sel_oob_rs");
    step(0, 0, 1, 3, 3'b111, 3'b000, 3'b000, 0, "sel_oob_lap");
    step(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 1, "sel1_view");
    step(1, 0, 0, 1, 3'b101, 3'b000, 3'b000, 0, "ch1_stop");
    step(0, 0, 0, 1, 3'b101, 3'b000, 3'b000, 0, "ch1_stopped");

    // Reset asserted while channel 0 is in LAP (and channel 1 in CLEAR in the edge build).
    step(0, 0, 1, 0, 3'b101, 3'b000, 3'b001, 1, "ch0_lap");
    step(0, 0, 0, 0, 3'b101, 3'b000, 3'b001, 1, "ch0_lap_hold");
`ifndef LONGPRESS_CLEAR_EN
    step(0, 1, 0, 1, 3'b101, 3'b010, 3'b001, 0, "ch1_clear");
`endif
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "reset_mid_a");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "reset_mid_b");
    reset = 1'b0;
    step(1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_after_reset");
    step(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1, "run_after_reset_hold");

`ifdef LONGPRESS_CLEAR_EN
    // Long-press clear: short and 99-cycle holds do nothing, 100 and 300 give one pulse each.
    step(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_stop");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_stopped");
    step(0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_short");
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_short_rel");
    for (int i = 0; i < HOLD_CYC - 1; i++) begin
      step(0, 1, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_hold99");
    end
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_rel99");
    for (int i = 0; i < HOLD_CYC; i++) begin
      step(0, 1, 0, 0, 3'b000, (i == HOLD_CYC - 1) ? 3'b001 : 3'b000, 3'b000, 0, "lp_hold100");
    end
    for (int i = 0; i < CLR_CYC - 1; i++) begin
      step(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 0, "lp_pulse_tail");
    end
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_pulse_done");
    for (int i = 0; i < 3 * HOLD_CYC; i++) begin
      step(0, 1, 0, 0, 3'b000,
           (i >= HOLD_CYC - 1 && i < HOLD_CYC - 1 + CLR_CYC) ? 3'b001 : 3'b000,
           3'b000, 0, "lp_hold300");
    end
    step(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, "lp_rel300");
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation never compared (due cyc %0d, now %0d)", m_e.name, m_e.cyc, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
